// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The datapath (master) supplies the fetched word and ALU flag; the controller (slave) drives everything else.
interface multicycle_control_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        pc_ld_en;
    logic        pc_sel;
    logic        rf_wr_en;
    logic        rf_wr_data_sel;
    logic        rf_b_sel;
    logic [1:0]  imm_ext;
    logic        alu_bin_sel;
    logic [3:0]  alu_func;
    logic        mem_wr_en;
    logic        byte_op;
    logic [31:0] ir;
    logic        illegal;

    modport master (
        output instr, alu_zero,
        input  pc_ld_en, pc_sel, rf_wr_en, rf_wr_data_sel, rf_b_sel,
        input  imm_ext, alu_bin_sel, alu_func, mem_wr_en, byte_op, ir, illegal
    );

    modport slave (
        input  instr, alu_zero,
        output pc_ld_en, pc_sel, rf_wr_en, rf_wr_data_sel, rf_b_sel,
        output imm_ext, alu_bin_sel, alu_func, mem_wr_en, byte_op, ir, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM controller for a multicycle CPU: latches the instruction in IFETCH
// and sequences ALU, register-file, memory and PC controls from state and IR.
module multicycle_control (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  ctl
);
    typedef enum logic [3:0] {
        S_IFETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [5:0]  opcode;
    logic        is_rtype, is_imm, is_load, is_store, is_branch, is_byte, uses_rt;
    logic [3:0]  exec_func;
    logic [1:0]  exec_imm;

    logic        pc_ld_en, pc_sel, rf_wr_en, rf_wr_data_sel, rf_b_sel;
    logic [1:0]  imm_ext;
    logic        alu_bin_sel, mem_wr_en, byte_op, illegal;
    logic [3:0]  alu_func;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IFETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign ir_d   = (state_q == S_IFETCH) ? ctl.instr : ir_q;
    assign opcode = ir_q[31:26];

    always_comb begin
        is_rtype  = (opcode == OP_RTYPE);
        is_imm    = (opcode == OP_LI) || (opcode == OP_LUI) || (opcode == OP_ADDI) ||
                    (opcode == OP_ANDI) || (opcode == OP_ORI);
        is_load   = (opcode == OP_LB) || (opcode == OP_LW);
        is_store  = (opcode == OP_SB) || (opcode == OP_SW);
        is_branch = (opcode == OP_B) || (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_byte   = (opcode == OP_LB) || (opcode == OP_SB);
        uses_rt   = (opcode == OP_SB) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_BNE);
    end

    // ALU setup of the execute step, reused in WB_ALU so the result stays stable while written back.
    always_comb begin
        exec_func = 4'b0000;
        exec_imm  = 2'b00;
        if (is_rtype) begin
            exec_func = ir_q[3:0];
        end else begin
            case (opcode)
                OP_ANDI: begin exec_func = 4'b0010; exec_imm = 2'b01; end
                OP_ORI:  begin exec_func = 4'b0011; exec_imm = 2'b01; end
                OP_LUI:  exec_imm = 2'b10;
                default: exec_imm = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IFETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (is_rtype)       state_d = S_EXEC_R;
                else if (is_imm)    state_d = S_EXEC_I;
                else if (is_load || is_store) state_d = S_MEM_ADDR;
                else if (is_branch) state_d = S_BRANCH;
                else                state_d = S_IFETCH;
            end
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = is_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_WB_MEM;
            S_WB_MEM:   state_d = S_IFETCH;
            S_MEM_WR:   state_d = S_IFETCH;
            S_WB_ALU:   state_d = S_IFETCH;
            S_BRANCH:   state_d = S_IFETCH;
            default:    state_d = S_IFETCH;
        endcase
    end

    // The effective address is held through the memory states so the access sees a stable ALU result.
    always_comb begin
        pc_ld_en       = 1'b0;
        pc_sel         = 1'b0;
        rf_wr_en       = 1'b0;
        rf_wr_data_sel = 1'b0;
        rf_b_sel       = uses_rt && (state_q != S_IFETCH);
        imm_ext        = 2'b00;
        alu_bin_sel    = 1'b0;
        alu_func       = 4'b0000;
        mem_wr_en      = 1'b0;
        byte_op        = 1'b0;
        illegal        = 1'b0;
        case (state_q)
            S_DECODE: begin
                if (!(is_rtype || is_imm || is_load || is_store || is_branch)) begin
                    illegal  = 1'b1;
                    pc_ld_en = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I, S_WB_ALU: begin
                alu_bin_sel = is_imm;
                alu_func    = exec_func;
                imm_ext     = exec_imm;
                if (state_q == S_WB_ALU) begin
                    rf_wr_en = 1'b1;
                    pc_ld_en = 1'b1;
                end
            end
            S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM: begin
                alu_bin_sel = 1'b1;
                byte_op     = is_byte;
                if (state_q == S_MEM_WR) begin
                    mem_wr_en = 1'b1;
                    pc_ld_en  = 1'b1;
                end
                if (state_q == S_WB_MEM) begin
                    rf_wr_en       = 1'b1;
                    rf_wr_data_sel = 1'b1;
                    pc_ld_en       = 1'b1;
                end
            end
            S_BRANCH: begin
                pc_ld_en = 1'b1;
                imm_ext  = 2'b11;
                alu_func = 4'b0001;
                pc_sel   = (opcode == OP_B) ||
                           ((opcode == OP_BEQ) && ctl.alu_zero) ||
                           ((opcode == OP_BNE) && !ctl.alu_zero);
            end
            default: ;
        endcase
    end

    assign ctl.pc_ld_en       = pc_ld_en;
    assign ctl.pc_sel         = pc_sel;
    assign ctl.rf_wr_en       = rf_wr_en;
    assign ctl.rf_wr_data_sel = rf_wr_data_sel;
    assign ctl.rf_b_sel       = rf_b_sel;
    assign ctl.imm_ext        = imm_ext;
    assign ctl.alu_bin_sel    = alu_bin_sel;
    assign ctl.alu_func       = alu_func;
    assign ctl.mem_wr_en      = mem_wr_en;
    assign ctl.byte_op        = byte_op;
    assign ctl.illegal        = illegal;
    assign ctl.ir             = ir_q;
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Clk  in  1  single system clock; all state updates on rising edge.
REQ-002 Reset_n  in  1  asynchronous, active-low reset; forces FSM to IFETCH and all outputs low immediately.
REQ-003 Instr  in  32  instruction word from fetch memory; sampled only in IFETCH.
REQ-004 ALU_zero  in  1  ALU zero flag, valid in BRANCH state.
REQ-005 PC_LdEn, PC_sel  out  1,1  PC load enable; PC_sel 0 = PC+4, 1 = PC+4+branch offset.
REQ-006 RF_WrEn, RF_WrData_sel, RF_B_sel  out  1,1,1  decode-stage controls: write enable; write data 0 = ALU_out, 1 = MEM_out; B read address 0 = Instr[15:11], 1 = Instr[20:16].
REQ-007 ImmExt  out  2  immediate mode: 00 sign-ext, 01 zero-ext, 10 <<16 zero-fill, 11 sign-ext <<2.
REQ-008 ALU_Bin_sel  out  1  0 = RF_B, 1 = Immed; ALU_func  out  4  ALU operation.
REQ-009 MEM_WrEn, ByteOp  out  1,1  data memory write strobe; byte (1) vs word (0) access.
REQ-010 IR  out  32  latched instruction driven to the decode stage; Illegal  out  1  one-cycle unknown-opcode pulse.

Function
REQ-011 The FSM SHALL have states IFETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH; outputs Moore, decoded from state and IR only (ALU_zero affects PC_sel only).
REQ-012 IFETCH: IR <= Instr; next DECODE; all control outputs 0.
REQ-013 Opcodes (IR[31:26]) SHALL be: 100000 R-type; 111000 li; 111001 lui; 110000 addi; 110010 andi; 110011 ori; 111111 b; 000000 beq; 000001 bne; 000011 lb; 001111 lw; 000111 sb; 011111 sw.
REQ-014 DECODE transitions: R-type -> EXEC_R; li/lui/addi/andi/ori -> EXEC_I; lb/lw/sb/sw -> MEM_ADDR; b/beq/bne -> BRANCH; other -> IFETCH with Illegal=1, PC_LdEn=1, PC_sel=0, no other write strobe.
REQ-015 EXEC_R -> WB_ALU; ALU_Bin_sel=0; ALU_func=IR[3:0].
REQ-016 EXEC_I -> WB_ALU; ALU_Bin_sel=1; ALU_func 0000 (li, lui, addi), 0010 (andi), 0011 (ori); ImmExt 00 (li, addi), 10 (lui), 01 (andi, ori).
REQ-017 WB_ALU -> IFETCH; RF_WrEn=1, RF_WrData_sel=0, PC_LdEn=1, PC_sel=0; ALU controls held from previous state.
REQ-018 MEM_ADDR: ALU_Bin_sel=1, ImmExt=00, ALU_func=0000; next MEM_RD for lb/lw, MEM_WR for sb/sw.
REQ-019 MEM_RD -> WB_MEM; WB_MEM: RF_WrEn=1, RF_WrData_sel=1, PC_LdEn=1, PC_sel=0 -> IFETCH.
REQ-020 MEM_WR: MEM_WrEn=1, PC_LdEn=1, PC_sel=0 -> IFETCH; RF_WrEn SHALL be 0.
REQ-021 ByteOp=1 for lb/sb in MEM_ADDR..WB_MEM/MEM_WR, else 0.
REQ-022 RF_B_sel=1 from DECODE to instruction end for sb, sw, beq, bne; 0 otherwise.
REQ-023 BRANCH -> IFETCH; PC_LdEn=1; ImmExt=11; ALU_func=0001, ALU_Bin_sel=0; PC_sel=1 for b, for beq when ALU_zero=1, for bne when ALU_zero=0; else 0.
REQ-024 Latency SHALL be: branch 3 cycles; R/I/store 4; load 5; illegal 2 (IFETCH to IFETCH).
REQ-025 RF_WrEn, MEM_WrEn, PC_LdEn SHALL each be high at most one cycle per instruction and never simultaneously with each other except PC_LdEn.
REQ-026 Instr changes outside IFETCH SHALL have no effect on outputs.

Reset
REQ-027 Reset_n=0 SHALL asynchronously set state=IFETCH, IR=0, all outputs 0, including mid-instruction (e.g. in WB_ALU or MEM_WR, strobe drops without waiting for Clk).
REQ-028 After Reset_n rises, the first rising edge SHALL perform IFETCH sampling.

Verification
REQ-029 add (Instr=0x80A41030): IFETCH, DECODE, EXEC_R, WB_ALU; ALU_func=0000; RF_WrEn=1 cycle 4 only; PC_LdEn=1, PC_sel=0.
REQ-030 lw (opcode 001111, imm 0x0004): 5 cycles; MEM_WrEn never 1; RF_WrData_sel=1 with RF_WrEn=1 in cycle 5.
REQ-031 sw then sb: MEM_WrEn=1 cycle 4; RF_B_sel=1 cycles 2-4; ByteOp=1 for sb only; RF_WrEn stays 0.
REQ-032 beq with ALU_zero=1 -> PC_sel=1 cycle 3; repeat with ALU_zero=0 -> PC_sel=0; bne inverse; b -> PC_sel=1 regardless.
REQ-033 opcode 101010: Illegal=1 and PC_LdEn=1 in cycle 2; back in IFETCH cycle 3; no RF/MEM write.
REQ-034 Reset_n pulsed low mid WB_ALU (between edges): RF_WrEn falls immediately; next instruction restarts at IFETCH with IR=0 until sampled.
